// File: rtl/ahb_ic_pkg.sv
// Shared types and constants for the single-master AHB3-Lite interconnect.
// Transfer types, default-slave states, response codes, select width helper.
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase select codes: NONE, DEF, then one per slave.
  function automatic int dsel_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR for unmapped transfers
// plus a saturating count of how many it has issued.
module ahb_default_slave
  import ahb_ic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HREADY,
  input  logic [1:0]       HTRANS,
  input  logic             sel_def,
  output logic             hreadyout,
  output logic             hresp,
  output logic [CNT_W-1:0] err_count
);

  ds_state_e        r_state;
  logic             r_rdy;
  logic             r_resp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req;

  assign w_req = HREADY && sel_def &&
                 ((HTRANS == NONSEQ) || (HTRANS == SEQ));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= DS_IDLE;
      r_rdy   <= 1'b1;
      r_resp  <= HRESP_OKAY;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        DS_IDLE, DS_ERR2: begin
          if (w_req) begin
            r_state <= DS_ERR1;
            r_rdy   <= 1'b0;
            r_resp  <= HRESP_ERROR;
            if (r_cnt != '1)
              r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= DS_IDLE;
            r_rdy   <= 1'b1;
            r_resp  <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          r_state <= DS_ERR2;
          r_rdy   <= 1'b1;
          r_resp  <= HRESP_ERROR;
        end
        default: begin
          r_state <= DS_IDLE;
          r_rdy   <= 1'b1;
          r_resp  <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout = r_rdy;
  assign hresp     = r_resp;
  assign err_count = r_cnt;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB3-Lite interconnect: priority address decoder,
// registered data-phase select, response mux and default slave.
module ahb_lite_interconnect
  import ahb_ic_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {4{16'hF000}},
  parameter int CNT_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic                         HREADY_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [CNT_W-1:0]             err_count
);

  localparam int DSW = dsel_w(NUM_SLAVES);
  localparam logic [DSW-1:0] D_NONE = '0;
  localparam logic [DSW-1:0] D_DEF  = DSW'(1);

  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [DSW-1:0]        w_widx;
  logic                  w_act;
  logic [DSW-1:0]        w_dnxt;
  logic [DSW-1:0]        r_dsel;
  logic                  w_def_rdy;
  logic                  w_def_resp;
  logic                  w_unused;

  // HWRITE is only tapped by the slaves.
  assign w_unused = HWRITE;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    w_hit  = 1'b0;
    w_sel  = '0;
    w_widx = D_NONE;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit    = 1'b1;
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_widx   = DSW'(i + 2);
      end
    end
  end

  assign HSEL_S = w_sel;
  assign w_act  = (HTRANS == NONSEQ) || (HTRANS == SEQ);
  assign w_dnxt = !w_act ? D_NONE : (w_hit ? w_widx : D_DEF);

  always_ff @(posedge HCLK) begin
    if (HRESET)
      r_dsel <= D_NONE;
    else if (HREADY)
      r_dsel <= w_dnxt;
  end

  ahb_default_slave #(
    .CNT_W(CNT_W)
  ) u_def (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HREADY   (HREADY),
    .HTRANS   (HTRANS),
    .sel_def  (!w_hit),
    .hreadyout(w_def_rdy),
    .hresp    (w_def_resp),
    .err_count(err_count)
  );

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    if (r_dsel == D_DEF) begin
      HREADY = w_def_rdy;
      HRESP  = w_def_resp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dsel == DSW'(i + 2)) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

  assign HREADY_S = HREADY;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Scoreboard bench for ahb_lite_interconnect with default parameters.
// A behavioural slave model answers each data phase; results are popped on HREADY.
module tb_ahb_lite_interconnect;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b1;
  logic [15:0]  HADDR = '0;
  logic [1:0]   HTRANS = '0;
  logic         HWRITE = 1'b0;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic [3:0]   HSEL_S;
  logic         HREADY_S;
  logic [127:0] HRDATA_S = '0;
  logic [3:0]   HREADYOUT_S = '1;
  logic [3:0]   HRESP_S = '0;
  logic [7:0]   err_count;

  ahb_lite_interconnect dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HSEL_S     (HSEL_S),
    .HREADY_S   (HREADY_S),
    .HRDATA_S   (HRDATA_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S    (HRESP_S),
    .err_count  (err_count)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] rd;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t sb[$];

  int n_run = 0;
  int n_fail = 0;
  int e_cnt = 0;

  bit          pd_valid = 0;
  int          pd_idx;
  int          pd_waits;
  logic [31:0] pd_rd;
  bit          pd_serr;
  int          pd_cnt;

  int          nx_waits;
  logic [31:0] nx_rd;
  bit          nx_serr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dec(input logic [15:0] a);
    return (a[15:12] < 4'd4) ? int'(a[15:12]) : -1;
  endfunction

  // One bus cycle: drive address phase, model the pending data phase.
  task automatic step(input logic act, input logic [15:0] a,
                      output bit acc);
    logic [127:0] v;
    int   tot;
    int   d;
    exp_t e;
    acc = 0;
    HADDR = a;
    HTRANS = act ? 2'b10 : 2'b00;
    HWRITE = 1'($urandom_range(0, 1));
    HREADYOUT_S = '1;
    HRESP_S = '0;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = $urandom;
    if (pd_valid && pd_idx >= 0) begin
      tot = pd_waits + (pd_serr ? 1 : 0);
      HREADYOUT_S[pd_idx] = (pd_cnt >= tot);
      HRESP_S[pd_idx] = pd_serr && (pd_cnt >= pd_waits);
      v[pd_idx*32 +: 32] = pd_rd;
    end
    HRDATA_S = v;
    @(negedge HCLK);
    d = dec(a);
    check("hsel", 64'(HSEL_S), (d >= 0) ? (64'd1 << d) : 64'd0);
    if (!pd_valid) begin
      check("idle_out", {HREADY, HRESP, HRDATA}, {1'b1, 1'b0, 32'd0});
    end else if (!HREADY) begin
      if (pd_idx < 0) check("err1_resp", 64'(HRESP), 64'd1);
      pd_cnt++;
      if (pd_cnt > 40) begin
        check("wait_timeout", 64'd0, 64'd1);
        pd_valid = 0;
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata", 64'(HRDATA), 64'(e.rd));
        check("resp", 64'(HRESP), 64'(e.resp));
        check("waits", 64'(pd_cnt), 64'(e.waits));
      end else begin
        check("sb_empty", 64'd0, 64'd1);
      end
      pd_valid = 0;
    end
    if (HREADY && act) begin
      acc = 1;
      pd_valid = 1;
      pd_idx = d;
      pd_waits = nx_waits;
      pd_rd = nx_rd;
      pd_serr = nx_serr;
      pd_cnt = 0;
      e.rd = (d >= 0) ? nx_rd : 32'd0;
      e.resp = (d >= 0) ? nx_serr : 1'b1;
      e.waits = (d >= 0) ? nx_waits + (nx_serr ? 1 : 0) : 1;
      sb.push_back(e);
      if (d < 0 && e_cnt < 255) e_cnt++;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic xfer(input logic [15:0] a, input int w,
                      input logic [31:0] rd, input bit se);
    bit acc;
    nx_waits = w;
    nx_rd = rd;
    nx_serr = se;
    acc = 0;
    for (int n = 0; n < 50 && !acc; n++) step(1'b1, a, acc);
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), acc);
  endtask

  function automatic logic [15:0] unmapped();
    return {4'(4 + $urandom_range(0, 11)), 12'($urandom)};
  endfunction

  initial begin
    bit acc;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_out", {HREADY, HRESP, HRDATA}, {1'b1, 1'b0, 32'd0});
    check("rst_cnt", 64'(err_count), 64'd0);
    @(posedge HCLK);
    #1;

    xfer(16'h2004, 0, 32'h12345678, 0);
    idle(2);
    xfer(16'h1010, 3, 32'hCAFEF00D, 0);
    idle(5);
    xfer(16'h0100, 1, 32'h0BADBEEF, 0);
    xfer(16'h3200, 0, 32'h33333333, 0);
    xfer(16'h2300, 2, 32'h22222222, 0);
    idle(5);
    xfer(16'h3008, 1, 32'h5A5A5A5A, 1);
    idle(4);
    check("cnt_slverr", 64'(err_count), 64'(e_cnt));

    xfer(16'h8000, 0, 32'h0, 0);
    idle(3);
    check("cnt_one", 64'(err_count), 64'(e_cnt));
    xfer(16'h9000, 0, 32'h0, 0);
    xfer(16'hA000, 0, 32'h0, 0);
    idle(3);
    check("cnt_b2b", 64'(err_count), 64'(e_cnt));
    xfer(16'hF000, 0, 32'h0, 0);
    xfer(16'h1000, 2, 32'h11112222, 0);
    idle(5);

    // Reset in the middle of a slave-3 wait run.
    nx_waits = 10;
    nx_rd = 32'h77778888;
    nx_serr = 0;
    step(1'b1, 16'h3040, acc);
    step(1'b0, 16'h3040, acc);
    step(1'b0, 16'h3040, acc);
    check("rst_mid_wait_pre", 64'(HREADY), 64'd0);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    pd_valid = 0;
    sb.delete();
    e_cnt = 0;
    @(negedge HCLK);
    check("rstw_out", {HREADY, HRESP, HRDATA}, {1'b1, 1'b0, 32'd0});
    check("rstw_cnt", 64'(err_count), 64'd0);
    @(posedge HCLK);
    #1;
    idle(2);

    for (int i = 0; i < 255; i++) xfer(unmapped(), 0, 32'h0, 0);
    idle(3);
    check("cnt_255", 64'(err_count), 64'd255);
    xfer(unmapped(), 0, 32'h0, 0);
    idle(3);
    check("cnt_sat", 64'(err_count), 64'(e_cnt));
    xfer(16'h2ABC, 1, 32'hFEEDFACE, 0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
